// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe turn sequencer: arbitrates player moves, owns the board registers
// and consumes the external winner checker's verdict to end or continue the game.
module ttt_game_ctrl #(
   parameter int unsigned TIMEOUT = 1000,
   parameter int unsigned SCORE_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               new_game,
   input  logic               p0_valid,
   input  logic [3:0]         p0_pos,
   input  logic               p1_valid,
   input  logic [3:0]         p1_pos,
   output logic               p0_ready,
   output logic               p1_ready,
   output logic               move_ack,
   output logic               move_err,
   output logic               timeout,
   output logic [8:0]         marked,
   output logic [8:0]         owner,
   input  logic               chk_draw,
   input  logic               chk_winner,
   input  logic               chk_game_over,
   output logic               turn,
   output logic               game_over,
   output logic               draw,
   output logic               winner,
   output logic [SCORE_W-1:0] score0,
   output logic [SCORE_W-1:0] score1
);

   localparam int unsigned CELLS    = 9;
   localparam int unsigned TMR_W    = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

   typedef enum logic [1:0] {
      WAIT_MOVE = 2'd0,
      CHECK     = 2'd1,
      DONE      = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CELLS-1:0]   marked_d, owner_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               start_q, start_d;
   logic               turn_d, ack_d, err_d, to_d;
   logic               go_d, draw_d, win_d;
   logic [SCORE_W-1:0] s0_d, s1_d;

   // Request of the current turn-holder; the other player is simply not looked at
   logic               req_valid;
   logic [3:0]         req_pos;
   logic [CELLS-1:0]   cell_oh;
   logic               legal;

   assign req_valid = turn ? p1_valid : p0_valid;
   assign req_pos   = turn ? p1_pos   : p0_pos;
   assign cell_oh   = CELLS'(16'd1 << req_pos);
   assign legal     = (req_pos <= 4'd8) && ((marked & cell_oh) == '0);

   assign p0_ready  = (state_q == WAIT_MOVE) && !turn;
   assign p1_ready  = (state_q == WAIT_MOVE) && turn;

   // Next-state and next-register values
   always_comb begin
      state_d  = state_q;
      marked_d = marked;
      owner_d  = owner;
      timer_d  = timer_q;
      start_d  = start_q;
      turn_d   = turn;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      to_d     = 1'b0;
      go_d     = game_over;
      draw_d   = draw;
      win_d    = winner;
      s0_d     = score0;
      s1_d     = score1;

      if (new_game) begin
         state_d  = WAIT_MOVE;
         marked_d = '0;
         owner_d  = '0;
         timer_d  = '0;
         go_d     = 1'b0;
         draw_d   = 1'b0;
         win_d    = 1'b0;
         start_d  = !start_q;
         turn_d   = !start_q;
      end else begin
         case (state_q)
            WAIT_MOVE: begin
               // Accepted move beats a same-cycle timeout; timeout beats an error
               if (req_valid && legal) begin
                  marked_d = marked | cell_oh;
                  owner_d  = owner | (cell_oh & {CELLS{turn}});
                  ack_d    = 1'b1;
                  timer_d  = '0;
                  state_d  = CHECK;
               end else if (timer_q == TMR_LAST) begin
                  to_d    = 1'b1;
                  turn_d  = !turn;
                  timer_d = '0;
               end else begin
                  err_d   = req_valid;
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            CHECK: begin
               if (chk_game_over) begin
                  go_d    = 1'b1;
                  draw_d  = chk_draw;
                  win_d   = chk_winner;
                  state_d = DONE;
                  if (!chk_draw) begin
                     if (chk_winner) begin
                        if (score1 != SCORE_MAX) s1_d = score1 + SCORE_W'(1);
                     end else begin
                        if (score0 != SCORE_MAX) s0_d = score0 + SCORE_W'(1);
                     end
                  end
               end else begin
                  turn_d  = !turn;
                  state_d = WAIT_MOVE;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = WAIT_MOVE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= WAIT_MOVE;
         marked    <= '0;
         owner     <= '0;
         timer_q   <= '0;
         start_q   <= 1'b0;
         turn      <= 1'b0;
         move_ack  <= 1'b0;
         move_err  <= 1'b0;
         timeout   <= 1'b0;
         game_over <= 1'b0;
         draw      <= 1'b0;
         winner    <= 1'b0;
         score0    <= '0;
         score1    <= '0;
      end else begin
         state_q   <= state_d;
         marked    <= marked_d;
         owner     <= owner_d;
         timer_q   <= timer_d;
         start_q   <= start_d;
         turn      <= turn_d;
         move_ack  <= ack_d;
         move_err  <= err_d;
         timeout   <= to_d;
         game_over <= go_d;
         draw      <= draw_d;
         winner    <= win_d;
         score0    <= s0_d;
         score1    <= s1_d;
      end
   end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl with a behavioural winner checker closing the loop.
module tb_ttt_game_ctrl;

   localparam int unsigned SW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          new_game, p0_valid, p1_valid;
   logic [3:0]    p0_pos, p1_pos;
   logic          p0_ready, p1_ready, move_ack, move_err, timeout;
   logic [8:0]    marked, owner;
   logic          chk_draw, chk_winner, chk_game_over;
   logic          turn, game_over, draw, winner;
   logic [SW-1:0] score0, score1;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ttt_game_ctrl #(.TIMEOUT(4), .SCORE_W(SW)) dut (
      .clk(clk), .rst(rst), .new_game(new_game),
      .p0_valid(p0_valid), .p0_pos(p0_pos), .p1_valid(p1_valid), .p1_pos(p1_pos),
      .p0_ready(p0_ready), .p1_ready(p1_ready),
      .move_ack(move_ack), .move_err(move_err), .timeout(timeout),
      .marked(marked), .owner(owner),
      .chk_draw(chk_draw), .chk_winner(chk_winner), .chk_game_over(chk_game_over),
      .turn(turn), .game_over(game_over), .draw(draw), .winner(winner),
      .score0(score0), .score1(score1)
   );

   // Reference winner checker driven from the registered board
   function automatic logic has_line(input logic [8:0] b);
      return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
             (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
             (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
   endfunction

   logic w0, w1;
   assign w0            = has_line(marked & ~owner);
   assign w1            = has_line(marked & owner);
   assign chk_winner    = w1;
   assign chk_draw      = (&marked) && !w0 && !w1;
   assign chk_game_over = w0 || w1 || chk_draw;

   typedef struct {
      logic       who;
      logic [3:0] pos;
      logic       ack;
      logic       err;
      logic [8:0] mk;
      logic [8:0] ow;
      logic       trn;
      logic       go;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle();
      p0_valid = 1'b0;
      p1_valid = 1'b0;
      new_game = 1'b0;
   endtask

   task automatic drive(input logic who, input logic [3:0] pos);
      p0_valid = ~who;
      p1_valid = who;
      p0_pos   = pos;
      p1_pos   = pos;
   endtask

   // Legal move by the turn-holder, including the CHECK cycle
   task automatic play(input logic who, input logic [3:0] pos);
      drive(who, pos);
      step();
      idle();
      check("play_ack", 9'(move_ack), 9'h1);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1);
   end

   initial begin
      int seq_a [5];
      int seq_b [6];
      logic who;
      logic [8:0] exp_s1;

      seq_a = '{0, 3, 1, 4, 2};
      seq_b = '{3, 0, 4, 1, 8, 2};

      vecs[0]  = '{1'b1, 4'd4, 1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 4'd0, 1'b1, 1'b0, 9'h001, 9'h000, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 4'd0, 1'b0, 1'b1, 9'h001, 9'h000, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 4'd4, 1'b1, 1'b0, 9'h011, 9'h010, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 4'd9, 1'b0, 1'b1, 9'h011, 9'h010, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 4'd4, 1'b0, 1'b1, 9'h011, 9'h010, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 4'd1, 1'b1, 1'b0, 9'h013, 9'h010, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 4'd5, 1'b1, 1'b0, 9'h033, 9'h030, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 4'd2, 1'b1, 1'b0, 9'h037, 9'h030, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 4'd8, 1'b0, 1'b0, 9'h037, 9'h030, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 4'd8, 1'b0, 1'b0, 9'h037, 9'h030, 1'b0, 1'b1};

      rst    = 1'b0;
      p0_pos = 4'd0;
      p1_pos = 4'd0;
      idle();
      #1;
      check("rst_marked", marked, 9'h000);
      check("rst_owner", owner, 9'h000);
      check("rst_turn", 9'(turn), 9'h0);
      check("rst_p0_ready", 9'(p0_ready), 9'h1);
      check("rst_pulses", 9'({move_ack, move_err, timeout}), 9'h0);
      check("rst_result", 9'({game_over, draw, winner}), 9'h0);
      check("rst_scores", 9'({score0, score1}), 9'h0);
      step();
      rst = 1'b1;

      // Row win for p0 with wrong-player, occupied and out-of-range requests mixed in
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].who, vecs[i].pos);
         step();
         idle();
         check($sformatf("v%0d_ack", i), 9'(move_ack), 9'(vecs[i].ack));
         check($sformatf("v%0d_err", i), 9'(move_err), 9'(vecs[i].err));
         check($sformatf("v%0d_marked", i), marked, vecs[i].mk);
         check($sformatf("v%0d_owner", i), owner, vecs[i].ow);
         if (vecs[i].ack) step();
         check($sformatf("v%0d_turn", i), 9'(turn), 9'(vecs[i].trn));
         check($sformatf("v%0d_over", i), 9'(game_over), 9'(vecs[i].go));
      end
      check("win_winner", 9'(winner), 9'h0);
      check("win_draw", 9'(draw), 9'h0);
      check("win_score0", 9'(score0), 9'h1);
      check("win_score1", 9'(score1), 9'h0);
      check("done_ready", 9'({p0_ready, p1_ready}), 9'h0);

      // Timeout: new game starts with p1, which idles and forfeits
      new_game = 1'b1;
      step();
      idle();
      check("ng_marked", marked, 9'h000);
      check("ng_turn", 9'(turn), 9'h1);
      check("ng_over", 9'(game_over), 9'h0);
      check("ng_score0_kept", 9'(score0), 9'h1);
      repeat (3) step();
      check("to_early", 9'(timeout), 9'h0);
      step();
      check("to_pulse", 9'(timeout), 9'h1);
      check("to_turn", 9'(turn), 9'h0);
      step();
      check("to_one_cycle", 9'(timeout), 9'h0);
      repeat (2) step();
      drive(1'b0, 4'd4);
      step();
      idle();
      check("to_race_ack", 9'(move_ack), 9'h1);
      check("to_race_to", 9'(timeout), 9'h0);
      step();
      check("to_race_turn", 9'(turn), 9'h1);
      check("to_race_marked", marked, 9'h010);

      // new_game beats a same-cycle legal move; then async reset during CHECK
      new_game = 1'b1;
      step();
      idle();
      check("ng2_turn", 9'(turn), 9'h0);
      new_game = 1'b1;
      drive(1'b0, 4'd0);
      step();
      idle();
      check("ngmv_marked", marked, 9'h000);
      check("ngmv_ack", 9'(move_ack), 9'h0);
      check("ngmv_turn", 9'(turn), 9'h1);
      check("ngmv_score0", 9'(score0), 9'h1);
      drive(1'b1, 4'd4);
      step();
      idle();
      check("pre_rst_marked", marked, 9'h010);
      rst = 1'b0;
      #1;
      check("arst_marked", marked, 9'h000);
      check("arst_owner", owner, 9'h000);
      check("arst_turn", 9'(turn), 9'h0);
      check("arst_ack", 9'(move_ack), 9'h0);
      check("arst_score0", 9'(score0), 9'h0);
      step();
      rst = 1'b1;
      check("arst_ready", 9'(p0_ready), 9'h1);

      // Draw: p0 {0,2,3,7,8}, p1 {1,4,5,6}
      begin
         int draw_seq [9];
         draw_seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
         for (int i = 0; i < 9; i++) begin
            play(1'(i % 2), 4'(draw_seq[i]));
            if (i < 8) check($sformatf("draw_turn%0d", i), 9'(turn), 9'(((i + 1) % 2)));
         end
      end
      check("draw_flag", 9'(draw), 9'h1);
      check("draw_over", 9'(game_over), 9'h1);
      check("draw_marked", marked, 9'h1ff);
      check("draw_owner", owner, 9'h072);
      check("draw_scores", 9'({score0, score1}), 9'h0);
      drive(1'b0, 4'd9);
      step();
      idle();
      check("done_err", 9'(move_err), 9'h0);
      check("done_ack", 9'(move_ack), 9'h0);

      // Four p1 wins with a 2-bit score: saturates at 3
      for (int g = 0; g < 4; g++) begin
         new_game = 1'b1;
         step();
         idle();
         if (g % 2 == 0) begin
            who = 1'b1;
            for (int i = 0; i < 5; i++) begin
               play(who, 4'(seq_a[i]));
               who = ~who;
            end
         end else begin
            who = 1'b0;
            for (int i = 0; i < 6; i++) begin
               play(who, 4'(seq_b[i]));
               who = ~who;
            end
         end
         exp_s1 = (g < 3) ? 9'(g + 1) : 9'd3;
         check($sformatf("sat_over%0d", g), 9'(game_over), 9'h1);
         check($sformatf("sat_winner%0d", g), 9'(winner), 9'h1);
         check($sformatf("sat_score1_%0d", g), 9'(score1), exp_s1);
         check($sformatf("sat_score0_%0d", g), 9'(score0), 9'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
